uart_boot_loader: RTL and testbench

- UART-side boot loader inside the cv32e40p FPGA system.
- Receives a framed program image on the RX pin (8N1), writes it word-by-word into instruction/data memory, then releases the core reset.
- It is the receiving end of the host/bench byte stream that uses ONbyte 0xAA and STPbyte 0x55.

---
 rtl/uart_boot_pkg.sv | 8 +
 rtl/uart_rx_byte.sv | 64 ++++++
 rtl/uart_boot_loader.sv | 103 ++++++++++
 tb/tb_uart_boot_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared state enums and constants for the UART boot loader.
package uart_boot_pkg;
  localparam logic [7:0] ON_BYTE_DEF  = 8'hAA;
  localparam logic [7:0] STP_BYTE_DEF = 8'h55;
  localparam int         UART_BITS    = 8;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, STOP, DONE} boot_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with two-flop RX synchroniser.
// Ports: Clk, Rst (sync, active high), RX (async serial in, idle high);
//        byte_valid (1-cycle pulse after a good stop bit), byte_data[7:0],
//        frame_err (1-cycle pulse when the stop bit reads 0).
module uart_rx_byte
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic      r_rx_s1, r_rx_s2, r_rx_d;
  rx_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic w_half, w_full, w_last_bit, w_stop_smp;
  assign w_half     = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign w_full     = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_last_bit = r_bit == 3'(UART_BITS - 1);
  assign w_stop_smp = r_state == RX_STOP && w_full;
  always_comb begin
    w_next = r_state;
    case (r_state)
      // Start needs a falling edge, so a line held low after a framing error
      // does not retrigger reception until it has returned high.
      RX_IDLE:  w_next = r_rx_d && !r_rx_s2 ? RX_START : RX_IDLE;
      RX_START: w_next = w_half ? (r_rx_s2 ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  w_next = w_full && w_last_bit ? RX_STOP : RX_DATA;
      RX_STOP:  w_next = w_full ? RX_IDLE : RX_STOP;
      default:  w_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_rx_s1    <= RX;
      r_rx_s2    <= r_rx_s1;
      r_rx_d     <= r_rx_s2;
      r_state    <= w_next;
      r_cnt      <= (r_state == RX_IDLE || w_next != r_state || w_full) ? '0 : r_cnt + 1'b1;
      byte_valid <= w_stop_smp && r_rx_s2;
      frame_err  <= w_stop_smp && !r_rx_s2;
      if (r_state == RX_DATA && w_full) begin
        byte_data <= {r_rx_s2, byte_data[7:1]};
        r_bit     <= r_bit + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed image over UART, writes it to memory, releases core reset.
// Ports: Clk, Rst (sync, active high), RX (serial in); mem_we/mem_addr/mem_wdata
//        (word write port), core_rst (held high until a frame completes),
//        boot_done (sticky success), boot_err (sticky error, cleared by ON_BYTE).
// Frame: ON_BYTE, LEN_LO, LEN_HI, 4*LEN bytes LE per word, [checksum], STP_BYTE.
// Define BOOT_CHECKSUM_EN to require a mod-256 data-byte sum before STP_BYTE.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1085,
  parameter int         ADDR_W       = 14,
  parameter logic [7:0] ON_BYTE      = ON_BYTE_DEF,
  parameter logic [7:0] STP_BYTE     = STP_BYTE_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RX,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              boot_done,
  output logic              boot_err
);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t TAIL = CSUM;
  logic [7:0] r_csum;
`else
  localparam boot_state_t TAIL = STOP;
`endif
  boot_state_t r_state, w_next;
  logic [15:0] r_len;
  logic [1:0]  r_k;
  logic        w_valid, w_ferr, w_start, w_err;
  logic [7:0]  w_byte;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clk       (Clk),
    .Rst       (Rst),
    .RX        (RX),
    .byte_valid(w_valid),
    .byte_data (w_byte),
    .frame_err (w_ferr)
  );
  assign w_start = r_state == IDLE && w_valid && w_byte == ON_BYTE;
  // Every transition back to IDLE from inside a frame is an error.
  assign w_err   = r_state != IDLE && w_next == IDLE;
  always_comb begin
    w_next = r_state;
    if (w_ferr && r_state != IDLE && r_state != DONE) w_next = IDLE;
    else if (w_valid)
      case (r_state)
        IDLE:    w_next = w_byte == ON_BYTE ? LEN0 : IDLE;
        LEN0:    w_next = LEN1;
        LEN1:    w_next = {w_byte, r_len[7:0]} == 16'd0 ? TAIL : DATA;
        DATA:    w_next = r_k == 2'd3 && r_len == 16'd1 ? TAIL : DATA;
`ifdef BOOT_CHECKSUM_EN
        CSUM:    w_next = w_byte == r_csum ? STOP : IDLE;
`endif
        STOP:    w_next = w_byte == STP_BYTE ? DONE : IDLE;
        default: w_next = r_state;
      endcase
    core_rst  = r_state != DONE;
    boot_done = r_state == DONE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_k       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      boot_err  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state <= w_next;
      mem_we  <= r_state == DATA && w_valid && r_k == 2'd3;
      if (w_start) begin
        mem_addr <= '0;
        r_k      <= '0;
        boot_err <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
        r_csum   <= '0;
`endif
      end else begin
        if (mem_we) mem_addr <= mem_addr + 1'b1;
        if (w_err) boot_err <= 1'b1;
      end
      if (w_valid && r_state == LEN0) r_len[7:0] <= w_byte;
      if (w_valid && r_state == LEN1) r_len[15:8] <= w_byte;
      if (w_valid && r_state == DATA) begin
        mem_wdata[{r_k, 3'b000} +: 8] <= w_byte;
        r_k <= r_k + 1'b1;
        if (r_k == 2'd3) r_len <= r_len - 1'b1;
`ifdef BOOT_CHECKSUM_EN
        r_csum <= r_csum + w_byte;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench driving UART frames into uart_boot_loader.
module tb_uart_boot_loader;
  localparam int CPB = 16;
  logic        Clk = 1'b0, Rst = 1'b1, RX = 1'b1;
  logic        mem_we, core_rst, boot_done, boot_err;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  typedef struct {logic [13:0] addr; logic [31:0] data;} wr_t;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] words[$];
  int          n_checks = 0, n_fail = 0;
  logic        prev_we = 1'b0;

  uart_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
    .Clk(Clk), .Rst(Rst), .RX(RX), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (mem_we) begin
      check("we_one_cycle", 64'(prev_we), 64'(0));
      check("we_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
        check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
      end
    end
    prev_we <= mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge Clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge Clk);
    RX = 1'b1;
    repeat (CPB) @(negedge Clk);
  endtask

  task automatic send_words(input logic [7:0] stp, input logic [7:0] cx);
    logic [7:0]  sum;
    logic [15:0] len;
    sum = '0;
    len = 16'(words.size());
    send_byte(8'hAA, 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back(wr_t'{14'(i), words[i]});
      for (int k = 0; k < 4; k++) begin
        sum = sum + words[i][8*k +: 8];
        send_byte(words[i][8*k +: 8], 1'b1);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(sum ^ cx, 1'b1);
`else
    if (cx != 0) $display("checksum disabled, byte %0h (sum %0h) not sent", cx, sum);
`endif
    send_byte(stp, 1'b1);
  endtask

  task automatic check_end(input string tag, input logic done, input logic err);
    repeat (4) @(negedge Clk);
    check({tag, "_done"}, 64'(boot_done), 64'(done));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(!done));
    check({tag, "_err"}, 64'(boot_err), 64'(err));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_done", 64'(boot_done), 64'(0));
    check("rst_err", 64'(boot_err), 64'(0));
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    words = '{32'h12345678, 32'hDEADBEEF};
    send_words(8'h55, 8'h00);
    check_end("normal", 1'b1, 1'b0);

    do_reset();
    send_byte(8'h55, 1'b1);
    send_byte(8'h13, 1'b1);
    send_words(8'h55, 8'h00);
    check_end("noise", 1'b1, 1'b0);

    do_reset();
    words = '{32'h04030201};
    send_words(8'h66, 8'h00);
    check_end("bad_stop", 1'b0, 1'b1);
    words = '{32'h12345678, 32'hDEADBEEF};
    send_words(8'h55, 8'h00);
    check_end("retry", 1'b1, 1'b0);

    do_reset();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check_end("ferr", 1'b0, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    check_end("ferr_idle", 1'b0, 1'b1);
    words = '{32'hCAFEF00D};
    send_words(8'h55, 8'h00);
    check_end("ferr_recover", 1'b1, 1'b0);

    do_reset();
    words = {};
    send_words(8'h55, 8'h00);
    check_end("zero_len", 1'b1, 1'b0);

    do_reset();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back(wr_t'{14'd0, 32'h12345678});
    foreach (words[i]) words.delete();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    check("mid_addr", 64'(mem_addr), 64'(1));
    RX = 1'b0;
    repeat (3 * CPB) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("mid_rst_core_rst", 64'(core_rst), 64'(1));
    check("mid_rst_addr", 64'(mem_addr), 64'(0));
    check("mid_rst_we", 64'(mem_we), 64'(0));
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    RX  = 1'b1;
    repeat (2 * CPB) @(negedge Clk);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h55, 1'b1);
    check_end("mid_rst", 1'b0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    words = '{32'h04030201};
    send_words(8'h55, 8'h00);
    check_end("csum_ok", 1'b1, 1'b0);
    do_reset();
    send_words(8'h55, 8'h01);
    check_end("csum_bad", 1'b0, 1'b1);
`endif

    repeat (4) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
